// File: rtl/mul_pkg.sv
// Shared definitions for the sequential shift-add multiplier:
// the controller state encoding and the default operand width.
package mul_pkg;

  localparam int WIDTH_DEFAULT = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mul_abs.sv
// Two's-complement to magnitude converter. The bypass input passes the
// operand through unchanged for unsigned operation.
module mul_abs
  import mul_pkg::*;
#(
  parameter int width = WIDTH_DEFAULT
) (
  input  logic [width-1:0] x,
  input  logic             bypass,
  output logic [width-1:0] mag
);

  // Negating -2^(width-1) yields the same bit pattern, which is the
  // correct magnitude when it is read as unsigned.
  always_comb begin
    if (bypass || !x[width-1]) begin
      mag = x;
    end else begin
      mag = ~x + {{(width-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/mul_seq_ctrl.sv
// Sequential shift-add multiplier for signed or unsigned operands: one
// multiplier bit per clock, a valid/ready handshake on both sides.
module mul_seq_ctrl
  import mul_pkg::*;
#(
  parameter int width = WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [width-1:0]   a,
  input  logic [width-1:0]   b,
  input  logic               sel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*width-1:0] out,
  output logic               busy
);

  localparam int CNT_W = $clog2(width);
  localparam int PW    = 2 * width;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [width-1:0] mag_a_s;
  logic [width-1:0] mag_b_s;
  logic [width-1:0] mag_a_r;
  logic [width-1:0] mag_b_r;
  logic             sign_r;
  logic [CNT_W-1:0] cnt_r;
  logic [PW-1:0]    acc_r;
  logic [PW-1:0]    shifted_s;
  logic [PW-1:0]    op_s;
  logic [PW-1:0]    sum_s;
  logic             bit_s;
  logic             cin_s;
  logic             accept_s;
  logic             last_s;

  mul_abs #(.width(width)) u_abs_a (.x(a), .bypass(sel), .mag(mag_a_s));
  mul_abs #(.width(width)) u_abs_b (.x(b), .bypass(sel), .mag(mag_b_s));

  assign accept_s = in_valid & in_ready;
  assign last_s   = (cnt_r == CNT_W'(width - 1));

  // Partial-product step. A negative result is built by subtracting each
  // partial product, so the final sum is already negated.
  always_comb begin
    bit_s     = mag_b_r[cnt_r];
    shifted_s = {{width{1'b0}}, mag_a_r} << cnt_r;
    if (!bit_s) begin
      op_s = '0;
    end else if (sign_r) begin
      op_s = ~shifted_s;
    end else begin
      op_s = shifted_s;
    end
    cin_s = sign_r & bit_s;
    sum_s = acc_r + op_s + {{(PW-1){1'b0}}, cin_s};
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_nxt_s = RUN;
        else          state_nxt_s = IDLE;
      end
      RUN: begin
        if (last_s) state_nxt_s = DONE;
        else        state_nxt_s = RUN;
      end
      DONE: begin
        if (accept_s)       state_nxt_s = RUN;
        else if (out_ready) state_nxt_s = IDLE;
        else                state_nxt_s = DONE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the state register.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_r)
      IDLE:    in_ready = 1'b1;
      RUN:     busy = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      default: in_ready = 1'b0;
    endcase
  end

  // Operand capture, accumulation and result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_a_r <= '0;
      mag_b_r <= '0;
      sign_r  <= 1'b0;
      cnt_r   <= '0;
      acc_r   <= '0;
      out     <= '0;
    end else if (accept_s) begin
      mag_a_r <= mag_a_s;
      mag_b_r <= mag_b_s;
      sign_r  <= ~sel & (a[width-1] ^ b[width-1]);
      cnt_r   <= '0;
      acc_r   <= '0;
    end else if (state_r == RUN) begin
      acc_r <= sum_s;
      cnt_r <= cnt_r + CNT_W'(1);
      if (last_s) begin
        out <= sum_s;
      end
    end
  end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl: directed corner cases plus random
// signed/unsigned pairs compared against an arithmetic product model.
module tb_mul_seq_ctrl;

  localparam int W = 6;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           sel;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] out;
  logic           busy;

  int n_chk  = 0;
  int n_fail = 0;

  mul_seq_ctrl #(.width(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] x, input logic [W-1:0] y,
                                              input logic s);
    longint p;
    if (s) p = longint'(x) * longint'(y);
    else   p = longint'($signed(x)) * longint'($signed(y));
    return p[2*W-1:0];
  endfunction

  // Present a pair in IDLE and step past the accept edge.
  task automatic accept_pair(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts);
    a = ta; b = tb; sel = ts; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Called just after an accept edge; waits (bounded) for out_valid.
  task automatic wait_done(input logic [2*W-1:0] exp, input bit toggle, input string tag);
    int lat = 0;
    bit ok_run = 1'b1;
    while (!out_valid && lat < 20) begin
      if (in_ready !== 1'b0 || busy !== 1'b1) ok_run = 1'b0;
      if (toggle) begin
        a = W'($urandom); b = W'($urandom); sel = 1'($urandom); in_valid = 1'($urandom);
      end
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    check_eq({tag, "_latency"}, lat, W);
    check_eq({tag, "_run_status"}, 32'(ok_run), 32'd1);
    check_eq({tag, "_out"}, 32'(out), 32'(exp));
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  logic [W-1:0] ra, rb;
  logic         rs;
  int           hold;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sel = 1'b0;
    #12;
    check_eq("rst_out", 32'(out), 32'd0);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1; #1;
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // -32 * -32 signed, with the result held for three cycles.
    accept_pair(6'h20, 6'h20, 1'b0);
    wait_done(12'h400, 1'b0, "neg32sq");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_eq("hold_valid", 32'(out_valid), 32'd1);
      check_eq("hold_out", 32'(out), 32'h400);
      check_eq("hold_in_ready", 32'(in_ready), 32'd0);
    end
    release_out();
    check_eq("idle_after_release", 32'(in_ready), 32'd1);

    accept_pair(6'h20, 6'h1F, 1'b0);
    wait_done(12'hC20, 1'b0, "neg32x31");
    release_out();
    accept_pair(6'h3F, 6'h3F, 1'b1);
    wait_done(12'hF81, 1'b0, "u63x63");

    // Back-to-back: next pair taken on the same edge that drains DONE.
    out_ready = 1'b1; a = 6'h07; b = 6'h3D; sel = 1'b0; in_valid = 1'b1; #1;
    check_eq("b2b_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    check_eq("b2b_busy", 32'(busy), 32'd1);
    check_eq("b2b_out_valid", 32'(out_valid), 32'd0);
    wait_done(ref_prod(6'h07, 6'h3D, 1'b0), 1'b0, "b2b");
    release_out();

    // Reset during RUN iteration 3, then 5 * -3.
    accept_pair(6'h15, 6'h2B, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0; #1;
    check_eq("midrst_out", 32'(out), 32'd0);
    check_eq("midrst_valid", 32'(out_valid), 32'd0);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1; #1;
    check_eq("midrst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    accept_pair(6'd5, 6'h3D, 1'b0);
    wait_done(12'hFF1, 1'b0, "after_rst");
    release_out();

    // Operands toggled while the multiply runs.
    accept_pair(6'h2A, 6'h13, 1'b0);
    wait_done(ref_prod(6'h2A, 6'h13, 1'b0), 1'b1, "toggle");
    release_out();

    // Random pairs, random consumer stalls.
    for (int n = 0; n < 200; n++) begin
      ra = W'($urandom); rb = W'($urandom); rs = 1'($urandom);
      accept_pair(ra, rb, rs);
      wait_done(ref_prod(ra, rb, rs), 1'b0, "rand");
      hold = int'($urandom_range(0, 2));
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
      end
      check_eq("rand_held", 32'(out), 32'(ref_prod(ra, rb, rs)));
      release_out();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
